// File: rtl/sdp_be_ram_model.sv
// Simple-dual-port RAM model with byte-enable writes, 1- or 2-cycle read latency,
// selectable read-during-write behaviour and per-lane "written since reset" flags.
module sdp_be_ram_model #(
  parameter int unsigned ABITS      = 10,
  parameter int unsigned DBITS      = 36,
  parameter int unsigned BYTEWIDTH  = 9,
  parameter int unsigned NBYTES     = DBITS / BYTEWIDTH,
  parameter int unsigned RD_LATENCY = 1,
  parameter int unsigned RDW_MODE   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [NBYTES-1:0] be,
  input  logic [ABITS-1:0]  wa,
  input  logic [DBITS-1:0]  wd,
  input  logic              re,
  input  logic [ABITS-1:0]  ra,
  output logic [DBITS-1:0]  rd,
  output logic              rd_valid,
  output logic [NBYTES-1:0] rd_bvalid
);

  localparam int unsigned DEPTH = 2 ** ABITS;

  if (DBITS != NBYTES * BYTEWIDTH) begin : g_bad_width
    $error("sdp_be_ram_model: DBITS must equal NBYTES*BYTEWIDTH");
  end
  if (RD_LATENCY != 1 && RD_LATENCY != 2) begin : g_bad_latency
    $error("sdp_be_ram_model: RD_LATENCY must be 1 or 2");
  end

  logic [DBITS-1:0]  mem_q   [DEPTH];
  logic [NBYTES-1:0] wmask_q [DEPTH];

  logic [DBITS-1:0]  s1_data;
  logic [NBYTES-1:0] s1_bv;
  logic              out_load;
  logic [DBITS-1:0]  out_data;
  logic [NBYTES-1:0] out_bv;

  logic [DBITS-1:0]  rd_q, rd_d;
  logic [NBYTES-1:0] rd_bvalid_q, rd_bvalid_d;
  logic              rd_valid_q, rd_valid_d;

  // Data array is deliberately left unreset; only the lane flags are cleared.
  always_ff @(posedge clk) begin
    if (we && !rst) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (be[i]) mem_q[wa][i*BYTEWIDTH +: BYTEWIDTH] <= wd[i*BYTEWIDTH +: BYTEWIDTH];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int j = 0; j < int'(DEPTH); j++) wmask_q[j] <= '0;
    end else if (we) begin
      wmask_q[wa] <= wmask_q[wa] | be;
    end
  end

  // Stage-1 read: array contents are pre-write; write-first mode overlays enabled lanes.
  always_comb begin
    s1_data = mem_q[ra];
    s1_bv   = wmask_q[ra];
    if (RDW_MODE == 1 && we && wa == ra) begin
      for (int i = 0; i < int'(NBYTES); i++) begin
        if (be[i]) begin
          s1_data[i*BYTEWIDTH +: BYTEWIDTH] = wd[i*BYTEWIDTH +: BYTEWIDTH];
          s1_bv[i]                          = 1'b1;
        end
      end
    end
  end

  if (RD_LATENCY == 2) begin : g_lat2
    logic              pipe_valid_q;
    logic [DBITS-1:0]  pipe_data_q;
    logic [NBYTES-1:0] pipe_bv_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        pipe_valid_q <= 1'b0;
        pipe_data_q  <= '0;
        pipe_bv_q    <= '0;
      end else begin
        pipe_valid_q <= re;
        if (re) begin
          pipe_data_q <= s1_data;
          pipe_bv_q   <= s1_bv;
        end
      end
    end

    assign out_load = pipe_valid_q;
    assign out_data = pipe_data_q;
    assign out_bv   = pipe_bv_q;
  end else begin : g_lat1
    assign out_load = re;
    assign out_data = s1_data;
    assign out_bv   = s1_bv;
  end

  // Output register holds the last result when no new one arrives.
  always_comb begin
    rd_d        = rd_q;
    rd_bvalid_d = rd_bvalid_q;
    rd_valid_d  = out_load;
    if (out_load) begin
      rd_d        = out_data;
      rd_bvalid_d = out_bv;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q        <= '0;
      rd_bvalid_q <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      rd_q        <= rd_d;
      rd_bvalid_q <= rd_bvalid_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign rd        = rd_q;
  assign rd_bvalid = rd_bvalid_q;
  assign rd_valid  = rd_valid_q;

endmodule

// File: tb/tb_sdp_be_ram_model.sv
// Runs all four RD_LATENCY x RDW_MODE variants side by side on shared stimulus
// and compares each against an array-based reference model.
module tb_sdp_be_ram_model;

  localparam int unsigned AW = 10;
  localparam int unsigned DW = 36;
  localparam int unsigned BW = 9;
  localparam int unsigned NB = 4;
  localparam int unsigned NI = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          we, re;
  logic [NB-1:0] be;
  logic [AW-1:0] wa, ra;
  logic [DW-1:0] wd;

  logic [DW-1:0] rd_w [NI];
  logic          rv_w [NI];
  logic [NB-1:0] bv_w [NI];

  always #5 clk = ~clk;

  // Instance k: RD_LATENCY = k/2+1, RDW_MODE = k%2.
  for (genvar k = 0; k < int'(NI); k++) begin : g_dut
    sdp_be_ram_model #(
      .ABITS(AW), .DBITS(DW), .BYTEWIDTH(BW), .NBYTES(NB),
      .RD_LATENCY(k / 2 + 1), .RDW_MODE(k % 2)
    ) u_dut (
      .clk(clk), .rst(rst), .we(we), .be(be), .wa(wa), .wd(wd),
      .re(re), .ra(ra), .rd(rd_w[k]), .rd_valid(rv_w[k]), .rd_bvalid(bv_w[k])
    );
  end

  logic [DW-1:0] mmem  [2**AW];
  logic [NB-1:0] mflag [2**AW];
  logic [DW-1:0] e_rd [NI];
  logic [NB-1:0] e_bv [NI];
  logic          e_v  [NI];
  logic [DW-1:0] p_rd [NI];
  logic [NB-1:0] p_bv [NI];
  logic          p_v  [NI];

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_val);
    n_checks++;
    if (obs !== exp_val) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_val, $time);
    end
  endtask

  function automatic logic [DW-1:0] lmask(input logic [NB-1:0] f);
    logic [DW-1:0] m = '0;
    for (int i = 0; i < int'(NB); i++) if (f[i]) m[i*BW +: BW] = '1;
    return m;
  endfunction

  function automatic logic [AW-1:0] rand_addr();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return '1;
      2:       return AW'($urandom_range(0, 7));
      default: return AW'($urandom);
    endcase
  endfunction

  task automatic model_clear();
    for (int j = 0; j < 2**AW; j++) mflag[j] = '0;
    for (int k = 0; k < int'(NI); k++) begin
      e_rd[k] = '0; e_bv[k] = '0; e_v[k] = 1'b0;
      p_rd[k] = '0; p_bv[k] = '0; p_v[k] = 1'b0;
    end
  endtask

  task automatic check_outs();
    for (int k = 0; k < int'(NI); k++) begin
      chk($sformatf("valid[%0d]", k), 64'(rv_w[k]), 64'(e_v[k]));
      chk($sformatf("bvalid[%0d]", k), 64'(bv_w[k]), 64'(e_bv[k]));
      if (e_v[k]) chk($sformatf("data[%0d]", k), 64'(rd_w[k] & lmask(e_bv[k])),
                      64'(e_rd[k] & lmask(e_bv[k])));
    end
  endtask

  // One clock of stimulus: drive, let the edge happen, advance the model, check.
  task automatic step(input logic w, input logic [NB-1:0] b, input logic [AW-1:0] a_w,
                      input logic [DW-1:0] d, input logic r, input logic [AW-1:0] a_r);
    logic [DW-1:0] old_d, new_d, res_d;
    logic [NB-1:0] old_f, new_f, res_f;
    we = w; be = b; wa = a_w; wd = d; re = r; ra = a_r;
    old_d = mmem[a_r];
    old_f = mflag[a_r];
    new_d = old_d;
    new_f = old_f;
    if (w && a_w == a_r) begin
      new_d = (old_d & ~lmask(b)) | (d & lmask(b));
      new_f = old_f | b;
    end
    @(posedge clk);
    for (int k = 0; k < int'(NI); k++) begin
      res_d = (k % 2 == 1) ? new_d : old_d;
      res_f = (k % 2 == 1) ? new_f : old_f;
      if (k < 2) begin
        e_v[k] = r;
        if (r) begin e_rd[k] = res_d; e_bv[k] = res_f; end
      end else begin
        e_v[k] = p_v[k];
        if (p_v[k]) begin e_rd[k] = p_rd[k]; e_bv[k] = p_bv[k]; end
        p_v[k] = r;
        if (r) begin p_rd[k] = res_d; p_bv[k] = res_f; end
      end
    end
    if (w) begin
      mmem[a_w]  = (mmem[a_w] & ~lmask(b)) | (d & lmask(b));
      mflag[a_w] = mflag[a_w] | b;
    end
    #1;
    check_outs();
  endtask

  task automatic idle();
    step(1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  // Asserts reset away from the clock edge and checks outputs clear at once.
  task automatic do_reset();
    #2;
    rst = 1'b1;
    we = 1'b0; re = 1'b0;
    #1;
    model_clear();
    for (int k = 0; k < int'(NI); k++) begin
      chk($sformatf("rst_rd[%0d]", k), 64'(rd_w[k]), 64'(0));
      chk($sformatf("rst_valid[%0d]", k), 64'(rv_w[k]), 64'(0));
      chk($sformatf("rst_bvalid[%0d]", k), 64'(bv_w[k]), 64'(0));
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  logic [DW-1:0] va, v5, vm;
  logic [AW-1:0] a;

  initial begin
    rst = 1'b0; we = 1'b0; re = 1'b0; be = '0; wa = '0; ra = '0; wd = '0;
    for (int j = 0; j < 2**AW; j++) mmem[j] = '0;
    model_clear();
    do_reset();

    // Unwritten read, then partial write and re-read.
    step(1'b0, '0, '0, '0, 1'b1, 10'h005);
    chk("t1_valid", 64'(rv_w[0]), 64'(1));
    chk("t1_bv_empty", 64'(bv_w[0]), 64'(0));
    step(1'b1, 4'b0101, 10'h005, 36'h1_2345_6789, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 10'h005);
    chk("t1_bv", 64'(bv_w[0]), 64'(4'b0101));
    chk("t1_lanes", 64'(rd_w[0] & lmask(4'b0101)), 64'(36'h1_2345_6789 & lmask(4'b0101)));

    // Partial-write merge at the top address; be=0 write must not disturb it.
    step(1'b1, 4'b0001, 10'h3FF, 36'h0_0000_01FF, 1'b0, '0);
    step(1'b1, 4'b1000, 10'h3FF, 36'hF_F800_0000, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 10'h3FF);
    chk("t2_bv", 64'(bv_w[0]), 64'(4'b1001));
    chk("t2_lane0", 64'(rd_w[0][8:0]), 64'(9'h1FF));
    chk("t2_lane3", 64'(rd_w[0][35:27]), 64'(9'h1FF));
    step(1'b1, 4'b0000, 10'h3FF, 36'h0_1234_5678, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 10'h3FF);
    chk("t2_be0_bv", 64'(bv_w[0]), 64'(4'b1001));
    chk("t2_be0_data", 64'(rd_w[0] & lmask(4'b1001)), 64'(36'hF_F800_01FF & lmask(4'b1001)));

    // Read-during-write collision.
    va = 36'hA_AAAA_AAAA;
    v5 = 36'h5_5555_5555;
    vm = {va[35:18], v5[17:0]};
    step(1'b1, 4'b1111, 10'h010, va, 1'b0, '0);
    step(1'b1, 4'b0011, 10'h010, v5, 1'b1, 10'h010);
    chk("t3_old", 64'(rd_w[0]), 64'(va));
    chk("t3_new", 64'(rd_w[1]), 64'(vm));
    step(1'b0, '0, '0, '0, 1'b1, 10'h010);
    chk("t3_merged0", 64'(rd_w[0]), 64'(vm));
    chk("t3_merged1", 64'(rd_w[1]), 64'(vm));

    // Latency-2 streaming with a one-cycle gap.
    for (int i = 1; i <= 4; i++) step(1'b1, 4'b1111, AW'(i), DW'(i * 36'h1_0101_0101), 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 10'd1);
    chk("t4_lat2_first", 64'(rv_w[2]), 64'(0));
    step(1'b0, '0, '0, '0, 1'b1, 10'd2);
    chk("t4_lat2_out1", 64'(rd_w[2]), 64'(36'h1_0101_0101));
    step(1'b0, '0, '0, '0, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 10'd3);
    chk("t4_gap", 64'(rv_w[2]), 64'(0));
    chk("t4_held", 64'(rd_w[2]), 64'(36'h2_0202_0202));
    step(1'b0, '0, '0, '0, 1'b1, 10'd4);
    idle();
    idle();

    // Reset while a latency-2 read is in flight.
    step(1'b1, 4'b1111, 10'h020, 36'h7_7777_7777, 1'b0, '0);
    step(1'b0, '0, '0, '0, 1'b1, 10'h020);
    do_reset();
    idle();
    chk("t5_no_result", 64'(rv_w[2]), 64'(0));
    step(1'b0, '0, '0, '0, 1'b1, 10'h020);
    idle();
    chk("t5_bv_cleared", 64'(bv_w[2]), 64'(0));

    // Randomised run with occasional resets.
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 499) == 0) do_reset();
      a = rand_addr();
      step(1'($urandom), NB'($urandom), ($urandom_range(0, 2) == 0) ? a : rand_addr(),
           DW'({$urandom, $urandom}), 1'($urandom_range(0, 3) != 0), a);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
